register_file_acc: RTL and testbench
====================================

Name: register_file_acc

Overview:
- Parametrised successor to the core's GPR file, used in the same decode/writeback position.
- Generalised data width, register count and number of read ports.
- r0 is hardwired to zero; HI/LO are exposed as outputs.
- Adds a subtract-accumulate mode and a handshaked sequential clear engine that zeroes the whole file without asserting reset.

Parameters:
- DATA_W, 32, width of each register, HI and LO
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, number of independent combinational read ports

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- write_enable  in  1  commit write/HI-LO operation this edge
- mul  in  2  operation mode: 0 GPR write, 1 HI/LO load, 2 HI/LO add-accumulate, 3 HI/LO subtract-accumulate
- write_address  in  ADDR_W  GPR destination (mode 0 only)
- write_data_1  in  DATA_W  GPR data (mode 0), or low half of 2*DATA_W operand (modes 1-3)
- write_data_2  in  DATA_W  high half of 2*DATA_W operand (modes 1-3); ignored in mode 0
- read_address  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- read_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
- hi_out  out  DATA_W  current HI
- lo_out  out  DATA_W  current LO
- clear_req  in  1  request full-file clear (level, sampled in IDLE)
- busy  out  1  clear engine active; writes are dropped
- clear_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (rst=0, asynchronous):
  - All GPR, HI and LO are 0.
  - FSM goes to IDLE; busy=0; clear_done=0.
  - Reset asserted mid-clear aborts the clear immediately.
- Reads:
  - Combinational, zero latency.
  - Address 0 returns 0 regardless of any write.
  - Ports are independent; any port may read any address.
- Writes: take effect at posedge only when write_enable=1 and busy=0; otherwise the state is unchanged.
  - mul=0: GPR[write_address] <= write_data_1. A write to address 0 is discarded. HI/LO unchanged.
  - mul=1: {HI,LO} <= {write_data_2, write_data_1}.
  - mul=2: {HI,LO} <= {HI,LO} + {write_data_2, write_data_1}, modulo 2^(2*DATA_W); no carry/overflow flag.
  - mul=3: {HI,LO} <= {HI,LO} - {write_data_2, write_data_1}, modulo 2^(2*DATA_W), two's-complement wrap.
  - Modes 1-3 never modify any GPR.
- Clear FSM states:
  - IDLE:
    - busy=0, clear_done=0.
    - clear_req=1 at posedge -> CLEAR, with cnt <= 1.
    - A write presented in that same cycle is still performed; it is later overwritten only if cnt reaches its address.
  - CLEAR:
    - busy=1; each posedge zeroes GPR[cnt] and increments cnt.
    - At cnt == NUM_REGS-1, also zeroes HI and LO, then -> DONE.
    - Duration is NUM_REGS-1 cycles (31 at default).
    - clear_req is ignored while in this state.
  - DONE:
    - clear_done=1 and busy=0 for exactly one cycle; writes are accepted in this cycle.
    - Always -> IDLE. If clear_req is still high in IDLE, a new clear starts.
- Reads during CLEAR return current contents (partially cleared file).
- busy and clear_done decode directly from the state register (glitch-free, registered state).

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined: a read port whose address equals write_address returns write_data_1 combinationally in the same cycle, when write_enable=1, mul=0, busy=0 and address != 0.
- Not defined: the read returns the old value until the next edge.
- HI/LO outputs are never bypassed in either build.

Test Plan:
- Reset, then write 0xDEADBEEF to r5, 0x12345678 to r0 -> next cycle r5 reads 0xDEADBEEF on both ports, r0 reads 0.
- mul=1 with 0x00000001/0xFFFFFFFF, then mul=2 with 0x00000000/0x00000001 -> HI=0x00000002, LO=0x00000000 (carry into HI).
- From {HI,LO}=0, mul=3 with 0x00000000/0x00000001 -> HI=LO=0xFFFFFFFF (wrap).
- Fill r1..r31 with nonzero values and load HI/LO; pulse clear_req -> busy high 31 cycles, then clear_done for 1 cycle; all regs, HI and LO read 0.
- Write r7=0xA5A5A5A5 while busy=1 -> r7 unchanged after clear; drop rst to 0 at cycle 10 of a clear -> busy=0 immediately, all state 0.
- Read r9 while writing r9=0x0000BEEF -> 0x0000BEEF same cycle with RF_BYPASS_EN defined, old value without it.

Source files
------------

// File: rtl/register_file_acc.sv
// Parametrised GPR file with HI/LO accumulator and a sequential clear engine.
// Define RF_BYPASS_EN to forward a same-cycle GPR write onto matching read ports.
module register_file_acc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_enable,
  input  logic [1:0]               mul,
  input  logic [ADDR_W-1:0]        write_address,
  input  logic [DATA_W-1:0]        write_data_1,
  input  logic [DATA_W-1:0]        write_data_2,
  input  logic [NUM_RD*ADDR_W-1:0] read_address,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [DATA_W-1:0]        hi_out,
  output logic [DATA_W-1:0]        lo_out,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     clear_done
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;

  logic                wr_ok;
  logic                gpr_wr;
  logic                last_clear;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] operand;
  logic [2*DATA_W-1:0] acc_next;

  assign wr_ok      = write_enable && (state != CLEAR);
  assign gpr_wr     = wr_ok && (mul == 2'd0) && (write_address != '0);
  assign last_clear = (state == CLEAR) && (cnt == '1);
  assign acc        = {hi, lo};
  assign operand    = {write_data_2, write_data_1};

  always_comb begin
    acc_next = acc;
    unique case (mul)
      2'd1:    acc_next = operand;
      2'd2:    acc_next = acc + operand;
      2'd3:    acc_next = acc - operand;
      default: acc_next = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= ADDR_W'(1);
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == CLEAR);
  assign clear_done = (state == DONE);

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (gpr_wr) begin
      regs[write_address] <= write_data_1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (last_clear) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_ok && (mul != 2'd0)) begin
      {hi, lo} <= acc_next;
    end
  end

  assign hi_out = hi;
  assign lo_out = lo;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = read_address[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      if (addr != '0) begin
`ifdef RF_BYPASS_EN
        if (gpr_wr && (addr == write_address)) data = write_data_1;
        else data = regs[addr];
`else
        data = regs[addr];
`endif
      end
    end

    assign read_data[k*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_register_file_acc.sv
// Scoreboard bench for register_file_acc: behavioural model predicts reads, HI/LO and
// clear status each cycle; a negedge monitor pops and compares.
module tb_register_file_acc;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int NREG = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              write_enable = 1'b0;
  logic [1:0]        mul = '0;
  logic [AW-1:0]     write_address = '0;
  logic [DW-1:0]     write_data_1 = '0;
  logic [DW-1:0]     write_data_2 = '0;
  logic [NR*AW-1:0]  read_address = '0;
  logic [NR*DW-1:0]  read_data;
  logic [DW-1:0]     hi_out;
  logic [DW-1:0]     lo_out;
  logic              clear_req = 1'b0;
  logic              busy;
  logic              clear_done;

  register_file_acc #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .mul(mul),
    .write_address(write_address), .write_data_1(write_data_1),
    .write_data_2(write_data_2), .read_address(read_address),
    .read_data(read_data), .hi_out(hi_out), .lo_out(lo_out),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [DW-1:0] rd0, rd1, hi, lo;
    logic busy, done;
  } exp_t;
  exp_t sb[$];

  // Reference model: the file as an array, {HI,LO} as one wide number, and the clear
  // as "edges elapsed since it started" (1..NREG-1 busy, NREG = done pulse).
  logic [DW-1:0]   m_reg [NREG];
  logic [2*DW-1:0] m_acc;
  int              m_age;

  function automatic bit m_busy();
    return (m_age >= 1) && (m_age <= NREG - 1);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (write_enable && mul == 2'd0 && !m_busy() && a == write_address) return write_data_1;
`endif
    return m_reg[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_acc = '0;
    m_age = 0;
  endtask

  task automatic m_edge();
    if (!rst) begin
      m_reset();
      return;
    end
    if (m_busy()) begin
      m_reg[m_age] = '0;
      if (m_age == NREG - 1) m_acc = '0;
      m_age++;
    end else begin
      if (write_enable) begin
        case (mul)
          2'd0: if (write_address != 0) m_reg[write_address] = write_data_1;
          2'd1: m_acc = {write_data_2, write_data_1};
          2'd2: m_acc = m_acc + {write_data_2, write_data_1};
          default: m_acc = m_acc - {write_data_2, write_data_1};
        endcase
      end
      if (m_age == NREG) m_age = 0;
      else if (clear_req) m_age = 1;
    end
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push();
    exp_t e;
    e.cyc  = cyc;
    e.rd0  = m_read(read_address[0 +: AW]);
    e.rd1  = m_read(read_address[AW +: AW]);
    e.hi   = m_acc[2*DW-1:DW];
    e.lo   = m_acc[DW-1:0];
    e.busy = m_busy();
    e.done = (m_age == NREG);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      cmp("sb_rd0", read_data[0 +: DW], e.rd0);
      cmp("sb_rd1", read_data[DW +: DW], e.rd1);
      cmp("sb_hi", hi_out, e.hi);
      cmp("sb_lo", lo_out, e.lo);
      cmp("sb_busy", DW'(busy), DW'(e.busy));
      cmp("sb_done", DW'(clear_done), DW'(e.done));
    end
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL sb_stale got cycle %0d expected cycle %0d", sb[0].cyc, cyc);
      sb.delete();
    end
  end

  task automatic set_in(input logic we, input logic [1:0] m, input logic [AW-1:0] wa,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic cr);
    write_enable  = we;
    mul           = m;
    write_address = wa;
    write_data_1  = d1;
    write_data_2  = d2;
    read_address  = {a1, a0};
    clear_req     = cr;
  endtask

  task automatic finish_cycle();
    push();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    set_in(1'b0, 2'd0, '0, '0, '0, a0, a1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    m_reset();
    @(posedge clk);
    #1;

    // Reset state
    idle_read(5'd5, 5'd0);
    #2;
    cmp("reset_busy", DW'(busy), '0);
    cmp("reset_hi", hi_out, '0);
    finish_cycle();
    finish_cycle();
    rst = 1'b1;

    // GPR write, r0 discard
    set_in(1'b1, 2'd0, 5'd5, 32'hDEADBEEF, '0, 5'd5, 5'd5, 1'b0);
    finish_cycle();
    set_in(1'b1, 2'd0, 5'd0, 32'h12345678, '0, 5'd5, 5'd5, 1'b0);
    #2;
    cmp("r5_port0", read_data[0 +: DW], 32'hDEADBEEF);
    cmp("r5_port1", read_data[DW +: DW], 32'hDEADBEEF);
    finish_cycle();
    idle_read(5'd0, 5'd0);
    #2;
    cmp("r0_zero", read_data[0 +: DW], '0);
    finish_cycle();

    // Accumulate with carry into HI
    set_in(1'b1, 2'd1, '0, 32'hFFFFFFFF, 32'h00000001, '0, '0, 1'b0);
    finish_cycle();
    set_in(1'b1, 2'd2, '0, 32'h00000001, 32'h00000000, '0, '0, 1'b0);
    finish_cycle();
    idle_read('0, '0);
    #2;
    cmp("carry_hi", hi_out, 32'h00000002);
    cmp("carry_lo", lo_out, 32'h00000000);
    finish_cycle();

    // Subtract wrap
    set_in(1'b1, 2'd1, '0, '0, '0, '0, '0, 1'b0);
    finish_cycle();
    set_in(1'b1, 2'd3, '0, 32'h00000001, 32'h00000000, '0, '0, 1'b0);
    finish_cycle();
    idle_read('0, '0);
    #2;
    cmp("wrap_hi", hi_out, 32'hFFFFFFFF);
    cmp("wrap_lo", lo_out, 32'hFFFFFFFF);
    finish_cycle();

    // Fill, then full clear with writes attempted while busy
    for (int i = 1; i < NREG; i++) begin
      set_in(1'b1, 2'd0, AW'(i), $urandom | 32'h1, $urandom, AW'($urandom), AW'($urandom), 1'b0);
      finish_cycle();
    end
    set_in(1'b1, 2'd1, '0, $urandom | 32'h1, $urandom | 32'h1, '0, '0, 1'b0);
    finish_cycle();
    set_in(1'b0, 2'd0, '0, '0, '0, AW'($urandom), AW'($urandom), 1'b1);
    finish_cycle();
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5)
        set_in(1'b1, 2'd0, 5'd7, 32'hA5A5A5A5, '0, 5'd7, AW'($urandom), 1'b0);
      else
        set_in(m_busy() ? 1'b1 : 1'b0, 2'($urandom), AW'($urandom), $urandom, $urandom,
               AW'($urandom), AW'($urandom), 1'b0);
      #2;
      if (busy) busy_cnt++;
      if (clear_done) done_cnt++;
      finish_cycle();
    end
    cmp("clear_busy_cycles", DW'(busy_cnt), DW'(NREG - 1));
    cmp("clear_done_pulses", DW'(done_cnt), 32'd1);
    for (int i = 0; i < NREG; i += 2) begin
      idle_read(AW'(i), AW'(i + 1));
      #2;
      cmp("cleared_rd0", read_data[0 +: DW], '0);
      cmp("cleared_rd1", read_data[DW +: DW], '0);
      finish_cycle();
    end
    cmp("cleared_hi", hi_out, '0);
    cmp("cleared_lo", lo_out, '0);

    // Reset in the middle of a clear
    for (int i = 1; i < 6; i++) begin
      set_in(1'b1, 2'd0, AW'(i * 5), $urandom | 32'h1, '0, '0, '0, 1'b0);
      finish_cycle();
    end
    set_in(1'b1, 2'd2, '0, 32'h55, 32'h66, '0, '0, 1'b1);
    finish_cycle();
    for (int k = 0; k < 10; k++) begin
      idle_read(AW'($urandom), AW'($urandom));
      finish_cycle();
    end
    rst = 1'b0;
    m_reset();
    idle_read(5'd10, 5'd25);
    #2;
    cmp("abort_busy", DW'(busy), '0);
    cmp("abort_r10", read_data[0 +: DW], '0);
    cmp("abort_hi", hi_out, '0);
    finish_cycle();
    rst = 1'b1;
    for (int i = 0; i < NREG; i += 2) begin
      idle_read(AW'(i), AW'(i + 1));
      finish_cycle();
    end

    // Same-cycle read of a register being written
    set_in(1'b1, 2'd0, 5'd9, 32'h00001111, '0, '0, '0, 1'b0);
    finish_cycle();
    set_in(1'b1, 2'd0, 5'd9, 32'h0000BEEF, '0, 5'd9, 5'd9, 1'b0);
    #2;
`ifdef RF_BYPASS_EN
    cmp("bypass_r9", read_data[0 +: DW], 32'h0000BEEF);
`else
    cmp("nobypass_r9", read_data[0 +: DW], 32'h00001111);
`endif
    finish_cycle();

    // Randomised traffic with occasional clears
    for (int k = 0; k < 600; k++) begin
      set_in(1'($urandom), 2'($urandom), AW'($urandom), $urandom, $urandom,
             AW'($urandom), AW'($urandom), ($urandom_range(0, 79) == 0));
      finish_cycle();
    end

    idle_read('0, '0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
